// File: rtl/fb_scanout.sv
// Raster-order frame-buffer reader presenting pixels as a valid/ready stream with x/y and sof/eol/eof markers.
// Latency: read issued the cycle after start, data captured 1 cycle later, pixel visible the cycle after capture.
// Backpressure: reads are issued only while count+inflight < DEPTH, so a stalled sink never overflows the FIFO.
module fb_scanout #(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 240,
    parameter int ADDR_W  = 17,
    parameter int COLOR_W = 24,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    input  logic               fb_grant,
    output logic               fb_rd_en,
    output logic [ADDR_W-1:0]  fb_addr,
    input  logic [COLOR_W-1:0] fb_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COLOR_W-1:0] pix_data,
    output logic [15:0]        pix_x,
    output logic [15:0]        pix_y,
    output logic               pix_sof,
    output logic               pix_eol,
    output logic               pix_eof,
    output logic               ready,
    output logic               frame_done
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [15:0]       X_LAST    = 16'(WIDTH - 1);
    localparam logic [15:0]       Y_LAST    = 16'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  rd_addr;
    logic               inflight;
    logic [CW-1:0]      count;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [COLOR_W-1:0] mem [DEPTH];
    logic [COLOR_W-1:0] hold;
    logic [15:0]        out_x, out_y;
    logic               credit, accept, rd_go;

    // An outstanding read already owns a FIFO slot.
    assign credit = (count + CW'(inflight)) < CW'(DEPTH);
    assign accept = pix_valid && pix_ready;

    always_comb begin
        state_nxt  = state;
        rd_go      = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SCAN;
            end
            SCAN: begin
                rd_go = fb_grant && credit;
                if (rd_go && rd_addr == LAST_ADDR) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (accept && pix_eof) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt  = IDLE;
            frame_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            rd_addr  <= '0;
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            out_x    <= '0;
            out_y    <= '0;
            hold     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) hold <= mem[rd_ptr];
            // Entering IDLE (abort or frame end) discards everything, including a read still in flight.
            if (state_nxt == IDLE) begin
                rd_addr  <= '0;
                inflight <= 1'b0;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                out_x    <= '0;
                out_y    <= '0;
            end else begin
                inflight <= rd_go;
                if (rd_go)    rd_addr <= rd_addr + 1'b1;
                if (inflight) wr_ptr  <= wr_ptr + 1'b1;
                if (accept)   rd_ptr  <= rd_ptr + 1'b1;
                count <= count + CW'(inflight) - CW'(accept);
                if (accept) begin
                    if (out_x == X_LAST) begin
                        out_x <= '0;
                        out_y <= out_y + 16'd1;
                    end else begin
                        out_x <= out_x + 16'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (inflight) mem[wr_ptr] <= fb_data;
    end

    assign fb_rd_en  = rd_go;
    assign fb_addr   = rd_addr;
    assign pix_valid = (count != '0);
    assign pix_data  = pix_valid ? mem[rd_ptr] : hold;
    assign pix_x     = out_x;
    assign pix_y     = out_y;
    assign pix_sof   = pix_valid && out_x == 16'd0 && out_y == 16'd0;
    assign pix_eol   = pix_valid && out_x == X_LAST;
    assign pix_eof   = pix_eol && out_y == Y_LAST;
    assign ready     = (state == IDLE);

endmodule
